// File: rtl/serial_flow_pkg.sv
// Shared types and constants for the serial-flow transmitter and comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_flow_pkg;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_GAP   = 1;
  localparam int MAX_GAP       = 15;
  localparam int GAP_CNT_W     = 4;

  // Bit-counter width for a frame of 'width' bits, never narrower than 1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Comparator-side verdict on the two serial flows.
  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_e;

endpackage

// File: rtl/serial_flow_shreg.sv
// Load / shift-right register with serial output (bit 0).
// Latency: loaded word's bit 0 visible the cycle after load; one bit per shift.
// Backpressure: none; load wins over shift. Ports: clock, reset_n, load, shift, din, sout.
module serial_flow_shreg
  import serial_flow_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = sh_q >> 1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign sout = sh_q[0];

endmodule

// File: rtl/serial_flow_tx.sv
// Parallel-to-serial transmitter: operand pairs out LSB-first on LINE1/LINE2 with frame/last strobes.
// Latency: bit 0 one cycle after handshake; frame period WIDTH (+GAP+1 idle when GAP > 0).
// Backpressure: in_ready in IDLE, and on the last bit slot when GAP == 0. Ports: clock, reset_n,
//   in_valid/in_ready/in_a/in_b, LINE1, LINE2, frame, last, busy.
module serial_flow_tx
  import serial_flow_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             LINE1,
  output logic             LINE2,
  output logic             frame,
  output logic             last,
  output logic             busy
);

  localparam int                   CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam bit                   HAS_GAP  = (GAP > 0);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = HAS_GAP ? GAP_CNT_W'(GAP - 1) : '0;
  localparam logic [GAP_CNT_W-1:0] GAP_ONE  = GAP_CNT_W'(1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;

  logic load;
  logic shift;
  logic accept;
  logic at_last;
  logic a_ser;
  logic b_ser;

  // Ready depends only on registered state, never on in_valid.
  assign at_last  = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign in_ready = (state_q == ST_IDLE) || (at_last && !HAS_GAP);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (cnt_q == '0) begin
          if (HAS_GAP) begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else if (accept) begin
            // Back-to-back frame: the load overrides the final shift.
            load    = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  serial_flow_shreg #(.WIDTH(WIDTH)) u_shreg_a (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .din     (in_a),
    .sout    (a_ser)
  );

  serial_flow_shreg #(.WIDTH(WIDTH)) u_shreg_b (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .din     (in_b),
    .sout    (b_ser)
  );

  // Outputs are decoded from registered state and shift-register bits only.
  assign frame = (state_q == ST_SHIFT);
  assign last  = at_last;
  assign busy  = (state_q != ST_IDLE);
  assign LINE1 = frame & a_ser;
  assign LINE2 = frame & b_ser;

endmodule

// File: tb/tb_serial_flow_tx.sv
// Bench for serial_flow_tx: three instances (W8/G1, W8/G0, W1/G0) against a slot-queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_flow_tx;

  typedef struct packed {
    logic l1;
    logic l2;
    logic fr;
    logic la;
  } slot_t;

  typedef struct packed {
    logic rdy;
    logic l1;
    logic l2;
    logic fr;
    logic la;
    logic bz;
  } obs_t;

  localparam int F_BZ  = 0;
  localparam int F_LA  = 1;
  localparam int F_FR  = 2;
  localparam int F_L2  = 3;
  localparam int F_L1  = 4;
  localparam int F_RDY = 5;

  logic       clk;
  logic       rst_n [3];
  logic       vld   [3];
  logic [7:0] a_v   [3];
  logic [7:0] b_v   [3];
  logic       rdy   [3];
  logic       l1    [3];
  logic       l2    [3];
  logic       fr    [3];
  logic       la    [3];
  logic       bz    [3];

  slot_t mq [3][$];
  obs_t  tr [3][$];
  bit    chk_en;
  int    n_cmp;
  int    n_bad;

  serial_flow_tx #(.WIDTH(8), .GAP(1)) u_w8g1 (
    .clock(clk), .reset_n(rst_n[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_a(a_v[0]), .in_b(b_v[0]), .LINE1(l1[0]), .LINE2(l2[0]),
    .frame(fr[0]), .last(la[0]), .busy(bz[0])
  );

  serial_flow_tx #(.WIDTH(8), .GAP(0)) u_w8g0 (
    .clock(clk), .reset_n(rst_n[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_a(a_v[1]), .in_b(b_v[1]), .LINE1(l1[1]), .LINE2(l2[1]),
    .frame(fr[1]), .last(la[1]), .busy(bz[1])
  );

  serial_flow_tx #(.WIDTH(1), .GAP(0)) u_w1g0 (
    .clock(clk), .reset_n(rst_n[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_a(a_v[2][0:0]), .in_b(b_v[2][0:0]), .LINE1(l1[2]), .LINE2(l2[2]),
    .frame(fr[2]), .last(la[2]), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of(input int i);
    return (i == 2) ? 1 : 8;
  endfunction

  function automatic int g_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // Model: a queue of upcoming output slots; the head is what the lines show now.
  // Ready whenever nothing is pending, or only the final bit slot is pending with no gap.
  function automatic bit exp_rdy(input int i);
    return (mq[i].size() == 0) || (g_of(i) == 0 && mq[i].size() == 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Gather one observed field over trace entries [from, from+n) into a bit vector.
  function automatic logic [31:0] mask(input int i, input int from, input int n, input int f);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++) begin
      obs_t o;
      o = tr[i][from + k];
      r[k] = o[f];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit acc;
      slot_t s;
      if (!rst_n[i]) begin
        mq[i].delete();
      end else begin
        acc = vld[i] && exp_rdy(i);
        if (mq[i].size() > 0) void'(mq[i].pop_front());
        if (acc) begin
          for (int b = 0; b < w_of(i); b++) begin
            s.l1 = a_v[i][b];
            s.l2 = b_v[i][b];
            s.fr = 1'b1;
            s.la = (b == w_of(i) - 1);
            mq[i].push_back(s);
          end
          for (int g = 0; g < g_of(i); g++) mq[i].push_back(slot_t'(0));
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      slot_t s;
      if (chk_en) begin
        s = (mq[i].size() > 0) ? mq[i][0] : slot_t'(0);
        chk($sformatf("u%0d in_ready", i), 32'(rdy[i]), 32'(exp_rdy(i)));
        chk($sformatf("u%0d LINE1", i),    32'(l1[i]),  32'(s.l1));
        chk($sformatf("u%0d LINE2", i),    32'(l2[i]),  32'(s.l2));
        chk($sformatf("u%0d frame", i),    32'(fr[i]),  32'(s.fr));
        chk($sformatf("u%0d last", i),     32'(la[i]),  32'(s.la));
        chk($sformatf("u%0d busy", i),     32'(bz[i]),  32'(mq[i].size() > 0));
      end
      tr[i].push_back({rdy[i], l1[i], l2[i], fr[i], la[i], bz[i]});
    end
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    chk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      vld[i]   = 1'b0;
      a_v[i]   = 8'h00;
      b_v[i]   = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d reset in_ready", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("u%0d reset frame", i),    32'(fr[i]),  32'd0);
    end

    // Single frame, W8 G1: A5/3C, one gap cycle, then ready.
    @(posedge clk); #1;
    tr[0].delete(); vld[0] = 1'b1; a_v[0] = 8'hA5; b_v[0] = 8'h3C;
    @(posedge clk); #1;
    vld[0] = 1'b0; a_v[0] = 8'h00; b_v[0] = 8'hFF;
    repeat (12) @(posedge clk); #1;
    chk("t1 LINE1 bits", mask(0, 1, 8, F_L1), 32'hA5);
    chk("t1 LINE2 bits", mask(0, 1, 8, F_L2), 32'h3C);
    chk("t1 frame",      mask(0, 1, 10, F_FR), 32'h0FF);
    chk("t1 last",       mask(0, 1, 10, F_LA), 32'h080);
    chk("t1 busy",       mask(0, 1, 10, F_BZ), 32'h1FF);
    chk("t1 in_ready",   mask(0, 0, 11, F_RDY), 32'h401);

    // Back-to-back, W8 G0: FF/00 then 01/80 with in_valid held.
    tr[1].delete(); vld[1] = 1'b1; a_v[1] = 8'hFF; b_v[1] = 8'h00;
    @(posedge clk); #1;
    a_v[1] = 8'h01; b_v[1] = 8'h80;
    repeat (8) @(posedge clk); #1;
    vld[1] = 1'b0; a_v[1] = 8'h00; b_v[1] = 8'h00;
    repeat (12) @(posedge clk); #1;
    chk("t2 LINE1 bits", mask(1, 1, 16, F_L1), 32'h01FF);
    chk("t2 LINE2 bits", mask(1, 1, 16, F_L2), 32'h8000);
    chk("t2 frame",      mask(1, 1, 17, F_FR), 32'h0FFFF);
    chk("t2 last",       mask(1, 1, 16, F_LA), 32'h8080);
    chk("t2 in_ready",   mask(1, 0, 18, F_RDY), 32'h30101);

    // Pair offered while busy with changed data: first frame keeps 5A/C3.
    tr[0].delete(); vld[0] = 1'b1; a_v[0] = 8'h5A; b_v[0] = 8'hC3;
    @(posedge clk); #1;
    a_v[0] = 8'hFF; b_v[0] = 8'hFF;
    repeat (10) @(posedge clk); #1;
    vld[0] = 1'b0; a_v[0] = 8'h00; b_v[0] = 8'h00;
    repeat (12) @(posedge clk); #1;
    chk("t3 LINE1 first",  mask(0, 1, 8, F_L1), 32'h5A);
    chk("t3 LINE2 first",  mask(0, 1, 8, F_L2), 32'hC3);
    chk("t3 in_ready",     mask(0, 0, 11, F_RDY), 32'h401);
    chk("t3 frame",        mask(0, 1, 18, F_FR), 32'h3FCFF);
    chk("t3 LINE1 second", mask(0, 11, 8, F_L1), 32'hFF);
    chk("t3 LINE2 second", mask(0, 11, 8, F_L2), 32'hFF);

    // Reset during bit 3, then a fresh pair 96/69.
    tr[0].delete(); vld[0] = 1'b1; a_v[0] = 8'hA5; b_v[0] = 8'h3C;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1; vld[0] = 1'b1; a_v[0] = 8'h96; b_v[0] = 8'h69;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("t4 frame before reset", mask(0, 1, 5, F_FR), 32'h0F);
    chk("t4 LINE1 partial",      mask(0, 1, 4, F_L1), 32'h5);
    chk("t4 LINE2 partial",      mask(0, 1, 4, F_L2), 32'hC);
    chk("t4 after reset",        32'(tr[0][5]), 32'h20);
    chk("t4 LINE1 new",          mask(0, 6, 8, F_L1), 32'h96);
    chk("t4 LINE2 new",          mask(0, 6, 8, F_L2), 32'h69);
    chk("t4 frame new",          mask(0, 6, 9, F_FR), 32'h0FF);

    // WIDTH=1 back-to-back: (1,1),(0,1),(1,0).
    tr[2].delete(); vld[2] = 1'b1; a_v[2] = 8'h01; b_v[2] = 8'h01;
    @(posedge clk); #1;
    a_v[2] = 8'h00; b_v[2] = 8'h01;
    @(posedge clk); #1;
    a_v[2] = 8'h01; b_v[2] = 8'h00;
    @(posedge clk); #1;
    vld[2] = 1'b0; a_v[2] = 8'h00; b_v[2] = 8'h00;
    repeat (4) @(posedge clk); #1;
    chk("t5 LINE1",    mask(2, 1, 3, F_L1), 32'h5);
    chk("t5 LINE2",    mask(2, 1, 3, F_L2), 32'h3);
    chk("t5 frame",    mask(2, 1, 4, F_FR), 32'h7);
    chk("t5 last",     mask(2, 1, 4, F_LA), 32'h7);
    chk("t5 in_ready", mask(2, 0, 5, F_RDY), 32'h1F);

    // Reset and handshake on the same edge: pair dropped.
    tr[0].delete(); rst_n[0] = 1'b0; vld[0] = 1'b1; a_v[0] = 8'hFF; b_v[0] = 8'hFF;
    @(posedge clk); #1;
    rst_n[0] = 1'b1; vld[0] = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("t6 frame",    mask(0, 0, 7, F_FR), 32'h0);
    chk("t6 LINE1",    mask(0, 0, 7, F_L1), 32'h0);
    chk("t6 LINE2",    mask(0, 0, 7, F_L2), 32'h0);
    chk("t6 in_ready", mask(0, 1, 6, F_RDY), 32'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
